delay_tuner_mc: RTL and testbench
=================================

// Module: delay_tuner_mc
// PURPOSE
//  Multi-channel, run-time tunable cycle-delay line for SPI-style strobes (cs/sdo/sclk).
//  The delay is set by two debounced push-buttons: up and down.
//  Successor to the single-channel, up-only, wrap-only delay shifter: adds width/depth/channel
//  parameters, a down button, a saturate/wrap mode, a status output and an optional lock.
//  Sits between the board pins and the SPI front-end; also used for bench skew tuning.
// PARAMETERS
//  NCH       3        number of delayed channels (1..16)
//  MAXD      16       delay taps; len range 0..MAXD-1; power of two, >=2
//  LEN_INIT  0        len value after reset
//  WRAP      1        1: len wraps MAXD-1<->0; 0: len saturates at the 0 and MAXD-1 ends
//  DIV       50_000   clk cycles per debounce sample tick (>=2)
//  N         8        consecutive equal samples needed to accept a new button level (>=2)
// PORTS
//  clk        in   1          system clock
//  rst        in   1          synchronous reset, active-high
//  din        in   NCH        channels to delay
//  btn_up     in   1          raw, asynchronous, bouncy button: increment len
//  btn_dn     in   1          raw, asynchronous, bouncy button: decrement len
//  dout       out  NCH        delayed channels
//  len        out  LEN_W      current delay; LEN_W = $clog2(MAXD)
//  len_upd    out  1          1-cycle pulse in the cycle after len changes
//  lock       in   1          only with DELAY_LOCK_EN: freeze len
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): hist<=0, len<=LEN_INIT, len_upd<=0, divider<=0,
//    synchronisers and debounce state <=0. dout is then 0 if len!=0; if len==0, dout follows din.
//    Reset mid-press: the press is discarded; a new press needs the full debounce again.
//  - Delay line: each cycle hist[0]<=din and hist[k]<=hist[k-1], for k<MAXD-1.
//  - Output select: dout = (len==0) ? din : hist[len-1].
//    len=0 is a purely combinational path with zero latency.
//    len=L>0 gives exactly L cycles of latency; a 1-cycle pulse stays 1 cycle wide.
//  - On a len change the history is not flushed. dout switches to the new tap at once; glitches
//    are accepted. All channels always share one len.
//  - Tick: a counter runs 0..DIV-1; tick=1 for one cycle when it reaches DIV-1; the counter then
//    restarts at 0.
//  - Debounce (per button): 2-FF synchroniser, then an N-bit shift register loaded on tick.
//    stable<=1 when all N bits are 1; stable<=0 when all N bits are 0; otherwise stable holds.
//    Each rising edge of stable gives a 1-cycle press pulse. Release and bounce give no pulse.
//  - Press latency: up to 2 + N*DIV + 1 cycles from a clean raw level until the pulse.
//    len updates on the next edge after the pulse.
//  - len update, evaluated each cycle from up_p and dn_p:
//      up_p & ~dn_p : len+1. At MAXD-1: 0 if WRAP, else hold.
//      dn_p & ~up_p : len-1. At 0: MAXD-1 if WRAP, else hold.
//      both, or none: hold.
//    len_upd=1 only when len actually changed. A saturated hold gives no pulse.
//  - Arithmetic is LEN_W-bit unsigned; wrap is the natural modulo-MAXD overflow.
// CONFIGURATION
//  DELAY_LOCK_EN defined:
//   - Adds the lock port.
//   - While lock=1, press pulses are ignored (len holds, no len_upd). Debounce keeps running,
//     so releasing lock does not replay a press.
//  DELAY_LOCK_EN undefined:
//   - No lock port; len always responds to presses.
// STRUCTURE
//  - Package delay_tuner_pkg: len_t typedef (logic [LEN_W-1:0] via a function/$clog2 helper);
//    constants for default DIV/N; enum {LEN_HOLD, LEN_INC, LEN_DEC} for the update decode.
//  - Sub-module btn_debounce: synchroniser, N-sample filter, rising-edge pulse.
//    Two instances; tick is supplied from the top-level divider, shared by both.
//  - The top holds the divider, the len register, the hist array and the output mux.
// TESTING  (short params: DIV=4, N=3, MAXD=16, NCH=3, LEN_INIT=0)
//  1. Reset then len=0: toggle din[0] 0->1->0 with a #1 check -> dout[0] equals din[0] in the
//     same timestep; len==0; len_upd==0.
//  2. Bouncy btn_up (1/0/1 over 6 cycles), then held 20 cycles and released 20 cycles
//     -> exactly one len_upd; len==1.
//     Then a 1-cycle pulse on din=3'b101 -> dout==3'b101 exactly 1 cycle later, for 1 cycle.
//  3. len=5, 1-cycle pulse on din[2] -> dout[2] high in the 5th cycle after the pulse only;
//     dout[1:0] stay 0.
//  4. WRAP=1: at len=15 press up -> len==0. At len=0 press dn -> len==15.
//     WRAP=0: the same presses -> len holds at 15 and 0, with no len_upd.
//  5. btn_up and btn_dn pressed in the same cycle (identical stimulus) -> len unchanged, no
//     len_upd. A 2-cycle glitch on btn_up (shorter than N ticks) -> no change.
//  6. rst asserted mid-debounce of btn_up -> len==LEN_INIT, hist cleared, no pulse after rst.
//     With DELAY_LOCK_EN: lock=1 during a press -> len holds; lock=0 afterwards -> still no
//     change.

Source files
------------

// File: rtl/delay_tuner_pkg.sv
// Shared types and defaults for the multi-channel tunable strobe delay line.
package delay_tuner_pkg;

    localparam int DEF_DIV  = 50_000;
    localparam int DEF_N    = 8;
    localparam int DEF_MAXD = 16;

    function automatic int len_width(input int maxd);
        return (maxd > 1) ? $clog2(maxd) : 1;
    endfunction

    localparam int DEF_LEN_W = len_width(DEF_MAXD);

    typedef logic [DEF_LEN_W-1:0] len_t;

    typedef enum logic [1:0] {
        LEN_HOLD,
        LEN_INC,
        LEN_DEC
    } len_op_e;

endpackage

// File: rtl/delay_tuner_mc_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, N-sample agreement filter, rising-edge press pulse.
module btn_debounce #(
    parameter int N = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    output logic press
);

    logic [1:0]   sync;
    logic [N-1:0] samp;
    logic         stable;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync   <= '0;
            samp   <= '0;
            stable <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            press <= 1'b0;
            if (tick)
                samp <= {samp[N-2:0], sync[1]};
            // mixed samples leave stable untouched, so bounce never toggles it
            if (&samp) begin
                stable <= 1'b1;
                press  <= ~stable;
            end else if (~|samp) begin
                stable <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/delay_tuner_mc.sv
// Multi-channel cycle-delay line whose tap is tuned by debounced up/down buttons.
// Optional freeze input enabled by defining DELAY_LOCK_EN.
module delay_tuner_mc
    import delay_tuner_pkg::*;
#(
    parameter  int NCH      = 3,
    parameter  int MAXD     = DEF_MAXD,
    parameter  int LEN_INIT = 0,
    parameter  int WRAP     = 1,
    parameter  int DIV      = DEF_DIV,
    parameter  int N        = DEF_N,
    localparam int LEN_W    = len_width(MAXD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   din,
    input  logic             btn_up,
    input  logic             btn_dn,
`ifdef DELAY_LOCK_EN
    input  logic             lock,
`endif
    output logic [NCH-1:0]   dout,
    output logic [LEN_W-1:0] len,
    output logic             len_upd
);

    localparam int              DIV_W   = $clog2(DIV);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAXD - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             up_p;
    logic             dn_p;
    len_op_e          op;
    logic [LEN_W-1:0] len_nxt;
    logic [NCH-1:0]   hist [MAXD-1];

    assign tick = (div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    btn_debounce #(.N(N)) u_deb_up (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .btn   (btn_up),
        .press (up_p)
    );

    btn_debounce #(.N(N)) u_deb_dn (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .btn   (btn_dn),
        .press (dn_p)
    );

    always_comb begin
        op = LEN_HOLD;
        if (up_p && !dn_p)
            op = LEN_INC;
        else if (dn_p && !up_p)
            op = LEN_DEC;
`ifdef DELAY_LOCK_EN
        // debouncers keep running under lock so a held press is not replayed later
        if (lock)
            op = LEN_HOLD;
`endif
        len_nxt = len;
        case (op)
            LEN_INC: if (!(len == LEN_MAX && WRAP == 0)) len_nxt = len + 1'b1;
            LEN_DEC: if (!(len == '0 && WRAP == 0))      len_nxt = len - 1'b1;
            default: len_nxt = len;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len     <= LEN_W'(LEN_INIT);
            len_upd <= 1'b0;
        end else begin
            len     <= len_nxt;
            len_upd <= (len_nxt != len);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MAXD - 1; k++)
                hist[k] <= '0;
        end else begin
            hist[0] <= din;
            for (int k = 1; k < MAXD - 1; k++)
                hist[k] <= hist[k-1];
        end
    end

    // tap changes take effect immediately; history is never flushed
    always_comb begin
        dout = din;
        if (len != '0)
            dout = hist[len - 1'b1];
    end

endmodule

// File: tb/tb_delay_tuner_mc.sv
// Scoreboard bench for delay_tuner_mc: a wrapping instance and a saturating instance.
module tb_delay_tuner_mc;

    localparam int NCH  = 3;
    localparam int MAXD = 16;
    localparam int DIV  = 4;
    localparam int N    = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] din;
    logic       up_a, dn_a, up_s, dn_s;
    logic       lock;
    logic [2:0] dout_a, dout_s;
    logic [3:0] len_a, len_s;
    logic       upd_a, upd_s;

    int n_checks = 0;
    int n_fail   = 0;
    int q_a[$];
    int q_s[$];
    int exp_a = 0;
    int exp_s = 0;

    always #5 clk = ~clk;

    delay_tuner_mc #(.NCH(NCH), .MAXD(MAXD), .LEN_INIT(0), .WRAP(1), .DIV(DIV), .N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .btn_up  (up_a),
        .btn_dn  (dn_a),
`ifdef DELAY_LOCK_EN
        .lock    (lock),
`endif
        .dout    (dout_a),
        .len     (len_a),
        .len_upd (upd_a)
    );

    delay_tuner_mc #(.NCH(NCH), .MAXD(MAXD), .LEN_INIT(0), .WRAP(0), .DIV(DIV), .N(N)) dut_s (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .btn_up  (up_s),
        .btn_dn  (dn_s),
`ifdef DELAY_LOCK_EN
        .lock    (1'b0),
`endif
        .dout    (dout_s),
        .len     (len_s),
        .len_upd (upd_s)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // every len_upd pulse must match the oldest outstanding expected len
    always @(negedge clk) begin
        if (upd_a) begin
            check("upd_a_expected", int'(q_a.size() > 0), 1);
            if (q_a.size() > 0) check("len_a_on_upd", int'(len_a), q_a.pop_front());
        end
        if (upd_s) begin
            check("upd_s_expected", int'(q_s.size() > 0), 1);
            if (q_s.size() > 0) check("len_s_on_upd", int'(len_s), q_s.pop_front());
        end
    end

    task automatic step_a(input int d);
        exp_a = (exp_a + d) & 15;
        q_a.push_back(exp_a);
    endtask

    task automatic step_s(input int d);
        int nv;
        nv = exp_s + d;
        if (nv >= 0 && nv <= 15) begin
            exp_s = nv;
            q_s.push_back(nv);
        end
    endtask

    task automatic press(input bit on_s, input bit up, input bit dn);
        @(posedge clk); #1;
        if (on_s) begin up_s = up; dn_s = dn; end
        else      begin up_a = up; dn_a = dn; end
        repeat (20) @(posedge clk);
        #1;
        up_a = 1'b0; dn_a = 1'b0; up_s = 1'b0; dn_s = 1'b0;
        repeat (20) @(posedge clk);
    endtask

    initial begin
        bit bounce [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        rst = 1'b1; din = '0; lock = 1'b0;
        up_a = 1'b0; dn_a = 1'b0; up_s = 1'b0; dn_s = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: len 0 is a combinational path
        @(negedge clk);
        check("reset_len_a", int'(len_a), 0);
        check("reset_upd_a", int'(upd_a), 0);
        check("reset_len_s", int'(len_s), 0);
        din = 3'b001; #1;
        check("len0_dout_hi", int'(dout_a[0]), 1);
        check("len0_dout_s_hi", int'(dout_s[0]), 1);
        din = 3'b000; #1;
        check("len0_dout_lo", int'(dout_a[0]), 0);

        // 2: bouncy press yields exactly one step
        step_a(1);
        @(posedge clk); #1;
        foreach (bounce[i]) begin
            up_a = bounce[i];
            @(posedge clk); #1;
        end
        up_a = 1'b1;
        repeat (20) @(posedge clk);
        #1 up_a = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("len_after_bouncy", int'(len_a), 1);

        @(posedge clk); #1 din = 3'b101;
        @(negedge clk); check("len1_before_capture", int'(dout_a), 0);
        @(posedge clk); #1 din = 3'b000;
        @(negedge clk); check("len1_pulse", int'(dout_a), 5);
        @(negedge clk); check("len1_after_pulse", int'(dout_a), 0);

        // 3: len 5, pulse on din[2]
        for (int i = 0; i < 4; i++) begin
            step_a(1);
            press(1'b0, 1'b1, 1'b0);
        end
        @(negedge clk); check("len_five", int'(len_a), 5);
        @(posedge clk); #1 din = 3'b100;
        @(posedge clk); #1 din = 3'b000;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check($sformatf("len5_tap_cycle%0d", k), int'(dout_a), (k == 5) ? 4 : 0);
            @(posedge clk);
        end

        // 4: wrap mode, down through 0 to 15, then up to 0
        for (int i = 0; i < 6; i++) begin
            step_a(-1);
            press(1'b0, 1'b0, 1'b1);
        end
        @(negedge clk); check("wrap_dn_to_15", int'(len_a), 15);
        step_a(1);
        press(1'b0, 1'b1, 1'b0);
        @(negedge clk); check("wrap_up_to_0", int'(len_a), 0);

        // saturating instance: dn at 0, up to 15, up at 15
        step_s(-1);
        press(1'b1, 1'b0, 1'b1);
        @(negedge clk); check("sat_hold_at_0", int'(len_s), 0);
        for (int i = 0; i < 16; i++) begin
            step_s(1);
            press(1'b1, 1'b1, 1'b0);
        end
        @(negedge clk); check("sat_hold_at_15", int'(len_s), 15);

        // 5: simultaneous presses and a short glitch
        press(1'b0, 1'b1, 1'b1);
        @(negedge clk); check("both_buttons_hold", int'(len_a), 0);
        @(posedge clk); #1 up_a = 1'b1;
        repeat (2) @(posedge clk);
        #1 up_a = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk); check("glitch_ignored", int'(len_a), 0);

        // 6: reset in the middle of a debounce
        step_a(1);
        press(1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        up_a = 1'b1; din = 3'b111;
        repeat (8) @(posedge clk);
        #1;
        @(negedge clk); check("pre_reset_dout", int'(dout_a), 7);
        @(posedge clk); #1;
        rst = 1'b1; up_a = 1'b0; din = 3'b000;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_a = 0; exp_s = 0;
        @(negedge clk);
        check("rst_len_a", int'(len_a), 0);
        check("rst_upd_a", int'(upd_a), 0);
        check("rst_dout_a", int'(dout_a), 0);
        check("rst_len_s", int'(len_s), 0);
        repeat (40) @(posedge clk);
        @(negedge clk); check("no_press_after_rst", int'(len_a), 0);

`ifdef DELAY_LOCK_EN
        lock = 1'b1;
        press(1'b0, 1'b1, 1'b0);
        @(negedge clk); check("lock_holds", int'(len_a), 0);
        #1 lock = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk); check("unlock_no_replay", int'(len_a), 0);
`endif

        check("queue_a_drained", q_a.size(), 0);
        check("queue_s_drained", q_s.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
